poly_control: RTL

Control block for the polynomial datapath. It sequences the 16-bit datapath through the ten micro-steps that compute resultado = A·X² + B·X + C, driving its mux selects (m0, m1, m2) and its load and operation strobes (lx, ls, lh, h). It exposes a start/busy/done handshake to the surrounding system. It is a Moore FSM and has no datapath of its own.

---
 rtl/poly_control.sv | 127 ++++++++++++
 1 files changed

// File: rtl/poly_control.sv
// poly_control: Moore sequencer for the polynomial datapath that computes
// resultado = A*X^2 + B*X + C in ten micro-steps (B..K), then pulses done.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset, forces IDLE
//   start      run request, sampled only in IDLE
//   m0/m1/m2   datapath mux selects (2 bits each)
//   lx         datapath enable (every compute state)
//   ls         load R1 from TEMP
//   lh         load R2 (TEMP, or X*X in state C)
//   h          operation select: 1 = multiply, 0 = add
//   busy       high in B..K and DONE
//   done       one-cycle pulse in DONE, resultado valid
module poly_control (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [1:0] m0,
  output logic [1:0] m1,
  output logic [1:0] m2,
  output logic       lx,
  output logic       ls,
  output logic       lh,
  output logic       h,
  output logic       busy,
  output logic       done
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 4'd0,
    ST_B    = 4'd1,
    ST_C    = 4'd2,
    ST_D    = 4'd3,
    ST_E    = 4'd4,
    ST_F    = 4'd5,
    ST_G    = 4'd6,
    ST_H    = 4'd7,
    ST_I    = 4'd8,
    ST_J    = 4'd9,
    ST_K    = 4'd10,
    ST_DONE = 4'd11
  } state_t;

  typedef struct packed {
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       lx;
    logic       ls;
    logic       lh;
    logic       h;
    logic       busy;
    logic       done;
  } ctrl_t;

  state_t state;
  ctrl_t  ctrl;

  // Successor state; illegal encodings fall back to IDLE.
  function automatic state_t next_state(input state_t s, input logic go);
    state_t n;
    n = ST_IDLE;
    case (s)
      ST_IDLE: n = go ? ST_B : ST_IDLE;
      ST_B:    n = ST_C;
      ST_C:    n = ST_D;
      ST_D:    n = ST_E;
      ST_E:    n = ST_F;
      ST_F:    n = ST_G;
      ST_G:    n = ST_H;
      ST_H:    n = ST_I;
      ST_I:    n = ST_J;
      ST_J:    n = ST_K;
      ST_K:    n = ST_DONE;
      default: n = ST_IDLE;
    endcase
    return n;
  endfunction

  // Per-state control word; IDLE, DONE and illegal states keep the datapath quiet.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_B: begin c.lx = 1'b1; c.h = 1'b1; end
      ST_C: begin c.lx = 1'b1; c.lh = 1'b1; c.h = 1'b1; end
      ST_D: begin c.m0 = 2'b01; c.m1 = 2'b01; c.m2 = 2'b11; c.lx = 1'b1; c.h = 1'b1; end
      ST_E: begin c.m0 = 2'b01; c.m1 = 2'b01; c.m2 = 2'b11; c.lx = 1'b1; c.lh = 1'b1; c.h = 1'b1; end
      ST_F: begin c.m0 = 2'b10; c.m1 = 2'b01; c.lx = 1'b1; c.h = 1'b1; end
      ST_G: begin c.m0 = 2'b10; c.m1 = 2'b01; c.lx = 1'b1; c.ls = 1'b1; c.h = 1'b1; end
      ST_H: begin c.m1 = 2'b11; c.m2 = 2'b10; c.lx = 1'b1; end
      ST_I: begin c.m1 = 2'b11; c.m2 = 2'b10; c.lx = 1'b1; c.lh = 1'b1; end
      ST_J: begin c.m0 = 2'b11; c.m1 = 2'b01; c.m2 = 2'b11; c.lx = 1'b1; end
      ST_K: begin c.m0 = 2'b11; c.m1 = 2'b01; c.m2 = 2'b11; c.lx = 1'b1; c.ls = 1'b1; end
      ST_DONE: begin c.busy = 1'b1; c.done = 1'b1; end
      default: c = '0;
    endcase
    if (s >= ST_B && s <= ST_K) c.busy = 1'b1;
    return c;
  endfunction

  // The control word is registered from the successor state, so it always
  // matches the state register without a decode stage after the flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ctrl  <= '0;
    end else begin
      state <= next_state(state, start);
      ctrl  <= decode(next_state(state, start));
    end
  end

  assign m0   = ctrl.m0;
  assign m1   = ctrl.m1;
  assign m2   = ctrl.m2;
  assign lx   = ctrl.lx;
  assign ls   = ctrl.ls;
  assign lh   = ctrl.lh;
  assign h    = ctrl.h;
  assign busy = ctrl.busy;
  assign done = ctrl.done;

endmodule
